// File: rtl/memory_pkg.sv
// Shared sizing constants for the register file, Register_32 and the other memory blocks.
package memory_pkg;

    localparam int         REG_WIDTH     = 32;
    localparam int         REG_ADDR_BITS = 5;
    localparam int         REG_COUNT     = 32;
    localparam logic [4:0] REG_ZERO      = 5'd0;

endpackage : memory_pkg

// File: rtl/decoder_5to32.sv
// Turns a write address plus enable into one-hot per-entry write strobes.
// Entry 0 never gets a strobe, which is what keeps $zero immutable.
module decoder_5to32
    import memory_pkg::*;
#(
    parameter int ADDR_BITS = REG_ADDR_BITS
) (
    input  logic                      en,
    input  logic [ADDR_BITS-1:0]      addr,
    output logic [(2**ADDR_BITS)-1:0] onehot
);

    always_comb begin
        onehot       = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
        onehot[0]    = 1'b0;
    end

endmodule : decoder_5to32

// File: rtl/register_file.sv
// 32 x 32 MIPS register file: clocked write port, two combinational read ports,
// entry 0 hardwired to zero, optional write-through bypass on the read ports.
module register_file
    import memory_pkg::*;
#(
    parameter int WIDTH     = REG_WIDTH,
    parameter int ADDR_BITS = REG_ADDR_BITS,
    parameter bit BYPASS    = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RegWrite,
    input  logic [ADDR_BITS-1:0] WriteReg,
    input  logic [WIDTH-1:0]     WriteData,
    input  logic [ADDR_BITS-1:0] ReadReg1,
    input  logic [ADDR_BITS-1:0] ReadReg2,
    output logic [WIDTH-1:0]     ReadData1,
    output logic [WIDTH-1:0]     ReadData2
);

    localparam int                   DEPTH = 2**ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] ZERO  = ADDR_BITS'(REG_ZERO);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] writeEnable;
    logic             bypassLive;
    logic             bypass1;
    logic             bypass2;

    decoder_5to32 #(
        .ADDR_BITS (ADDR_BITS)
    ) u_decoder (
        .en     (RegWrite),
        .addr   (WriteReg),
        .onehot (writeEnable)
    );

    // Reset wins over a coincident write; regs[0] is cleared but never written,
    // and the read muxes mask it anyway so it reads 0 even before reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (writeEnable[i]) begin
                    regs[i] <= WriteData;
                end
            end
        end
    end

    always_comb begin
        bypassLive = BYPASS && RegWrite && !reset && (WriteReg != ZERO);
        bypass1    = bypassLive && (ReadReg1 == WriteReg);
        bypass2    = bypassLive && (ReadReg2 == WriteReg);
    end

    always_comb begin
        ReadData1 = '0;
        if (ReadReg1 != ZERO) begin
            ReadData1 = bypass1 ? WriteData : regs[ReadReg1];
        end
    end

    always_comb begin
        ReadData2 = '0;
        if (ReadReg2 != ZERO) begin
            ReadData2 = bypass2 ? WriteData : regs[ReadReg2];
        end
    end

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed bench for register_file: one plain instance and one write-through instance
// share the same stimulus.
module tb_register_file;

    localparam int CLK_PERIOD = 20;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] rdN1, rdN2, rdB1, rdB2;

    int checks = 0;
    int errors = 0;

    register_file #(.WIDTH(32), .ADDR_BITS(5), .BYPASS(1'b0)) dut_n (
        .clk       (clk),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .ReadData1 (rdN1),
        .ReadData2 (rdN2)
    );

    register_file #(.WIDTH(32), .ADDR_BITS(5), .BYPASS(1'b1)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .ReadData1 (rdB1),
        .ReadData2 (rdB2)
    );

    initial clk = 1'b0;
    always #(CLK_PERIOD/2) clk = ~clk;

    // Drive all inputs at once.
    task automatic applyStimulus(input logic rst, input logic we, input logic [4:0] wr,
                                 input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
        reset     = rst;
        RegWrite  = we;
        WriteReg  = wr;
        WriteData = wd;
        ReadReg1  = r1;
        ReadReg2  = r2;
    endtask

    // Advance past one rising edge and park in the middle of the low phase.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #(CLK_PERIOD/4);
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        #1;
        checks++;
        if (rdN1 !== 32'd0 || rdN2 !== 32'd0) begin
            errors++;
            $display("[TB] FAIL zero_before_reset: got %h/%h expected 0/0", rdN1, rdN2);
        end
        applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd31);
        step();
        checks++;
        if (rdN1 !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL preload_5: got %h expected deadbeef", rdN1);
        end
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd31);
        step();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd31);
        #1;
        checks++;
        if (rdN1 !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_clears_5: got %h expected 0", rdN1);
        end
        checks++;
        if (rdN2 !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_clears_31: got %h expected 0", rdN2);
        end
    endtask

    task automatic test_write_read();
        applyStimulus(1'b0, 1'b0, 5'd8, 32'd52, 5'd8, 5'd8);
        @(posedge clk);
        #(CLK_PERIOD/4);
        // Write request goes up in the high phase so a falling edge precedes the rising one.
        RegWrite = 1'b1;
        @(negedge clk);
        #(CLK_PERIOD/4);
        checks++;
        if (rdN1 !== 32'd0) begin
            errors++;
            $display("[TB] FAIL falling_edge_no_write: got %h expected 0", rdN1);
        end
        step();
        checks++;
        if (rdN1 !== 32'd52) begin
            errors++;
            $display("[TB] FAIL write_8: got %h expected 00000034", rdN1);
        end
    endtask

    task automatic test_zero_reg();
        applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        step();
        RegWrite = 1'b0;
        #1;
        checks++;
        if (rdN1 !== 32'd0) begin
            errors++;
            $display("[TB] FAIL zero_port1: got %h expected 0", rdN1);
        end
        checks++;
        if (rdN2 !== 32'd0) begin
            errors++;
            $display("[TB] FAIL zero_port2: got %h expected 0", rdN2);
        end
    endtask

    task automatic test_dual_port();
        applyStimulus(1'b0, 1'b1, 5'd17, 32'h12345678, 5'd0, 5'd0);
        step();
        applyStimulus(1'b0, 1'b1, 5'd18, 32'h0000ABCD, 5'd0, 5'd0);
        step();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd17, 5'd18);
        #1;
        checks++;
        if (rdN1 !== 32'h12345678 || rdN2 !== 32'h0000ABCD) begin
            errors++;
            $display("[TB] FAIL dual_read: got %h/%h expected 12345678/0000abcd", rdN1, rdN2);
        end
        ReadReg1 = 5'd18;
        ReadReg2 = 5'd18;
        #1;
        checks++;
        if (rdN1 !== 32'h0000ABCD || rdN2 !== 32'h0000ABCD) begin
            errors++;
            $display("[TB] FAIL same_reg_both_ports: got %h/%h expected 0000abcd/0000abcd", rdN1, rdN2);
        end
        applyStimulus(1'b0, 1'b0, 5'd17, 32'd1, 5'd17, 5'd8);
        step();
        checks++;
        if (rdN1 !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL write_disabled: got %h expected 12345678", rdN1);
        end
        checks++;
        if (rdN2 !== 32'd52) begin
            errors++;
            $display("[TB] FAIL reg8_retained: got %h expected 00000034", rdN2);
        end
    endtask

    task automatic test_reset_collision();
        applyStimulus(1'b1, 1'b1, 5'd9, 32'd77, 5'd9, 5'd17);
        step();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd17);
        #1;
        checks++;
        if (rdN1 !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_beats_write: got %h expected 0", rdN1);
        end
        checks++;
        if (rdN2 !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_clears_committed: got %h expected 0", rdN2);
        end
    endtask

    task automatic test_bypass();
        applyStimulus(1'b0, 1'b1, 5'd10, 32'd3, 5'd0, 5'd0);
        step();
        applyStimulus(1'b0, 1'b1, 5'd10, 32'd99, 5'd10, 5'd10);
        #1;
        checks++;
        if (rdB1 !== 32'd99 || rdB2 !== 32'd99) begin
            errors++;
            $display("[TB] FAIL bypass_before_edge: got %h/%h expected 63/63", rdB1, rdB2);
        end
        checks++;
        if (rdN1 !== 32'd3 || rdN2 !== 32'd3) begin
            errors++;
            $display("[TB] FAIL nobypass_before_edge: got %h/%h expected 3/3", rdN1, rdN2);
        end
        step();
        RegWrite = 1'b0;
        #1;
        checks++;
        if (rdN1 !== 32'd99 || rdB1 !== 32'd99) begin
            errors++;
            $display("[TB] FAIL after_edge_99: got %h/%h expected 63/63", rdN1, rdB1);
        end
        // Address 0 must never be bypassed.
        applyStimulus(1'b0, 1'b1, 5'd0, 32'd5, 5'd0, 5'd10);
        #1;
        checks++;
        if (rdB1 !== 32'd0 || rdB2 !== 32'd99) begin
            errors++;
            $display("[TB] FAIL bypass_zero_addr: got %h/%h expected 0/63", rdB1, rdB2);
        end
        RegWrite = 1'b0;
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        @(negedge clk);
        #(CLK_PERIOD/4);
        test_reset();
        test_write_read();
        test_zero_reg();
        test_dual_port();
        test_reset_collision();
        test_bypass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_register_file
